// File: rtl/flags_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flags_wb_pkg
//  Description : Shared constants and helpers for the flags writeback block:
//                compact flag indices, EFLAGS bit positions, reset image.
//  Revision    : 1.0 - initial release
// ============================================================================
package flags_wb_pkg;

  // Compact 6-bit flag vector indices (ALU / CMPS / load-enable order)
  localparam int c_CF     = 0;
  localparam int c_PF     = 1;
  localparam int c_AF     = 2;
  localparam int c_ZF     = 3;
  localparam int c_SF     = 4;
  localparam int c_OF     = 5;
  localparam int c_NFLAGS = 6;

  // Architectural EFLAGS bit positions
  localparam int c_EF_CF = 0;
  localparam int c_EF_PF = 2;
  localparam int c_EF_AF = 4;
  localparam int c_EF_ZF = 6;
  localparam int c_EF_SF = 7;
  localparam int c_EF_DF = 10;
  localparam int c_EF_OF = 11;

  // Reset image: only the always-one reserved bit 1 is set
  localparam logic [15:0] c_EFLAGS_RST = 16'h0002;

  // Map a compact flag index onto its EFLAGS bit position
  function automatic int ef_pos(input int idx);
    case (idx)
      c_CF:    ef_pos = c_EF_CF;
      c_PF:    ef_pos = c_EF_PF;
      c_AF:    ef_pos = c_EF_AF;
      c_ZF:    ef_pos = c_EF_ZF;
      c_SF:    ef_pos = c_EF_SF;
      default: ef_pos = c_EF_OF;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/flags_merge.sv
`default_nettype none
// ============================================================================
//  Module      : flags_merge
//  Description : Combinational merge of one writeback entry onto an EFLAGS
//                image. POPF replaces the whole image; otherwise each flag
//                and DF is individually loaded or held.
//  Revision    : 1.0 - initial release
// ============================================================================
module flags_merge
  import flags_wb_pkg::*;
(
  input  logic [15:0] old_flags,
  input  logic        popf,
  input  logic [5:0]  ld_flag,
  input  logic [5:0]  src,
  input  logic        ld_df,
  input  logic        df_val,
  input  logic [15:0] pop_img,
  output logic [15:0] new_flags
);

  // Only the architectural bit positions of the POPF image are consumed
  logic w_unused_pop;
  assign w_unused_pop = &{1'b0, pop_img[15:12], pop_img[9:8], pop_img[5], pop_img[3:1]};

  // Build the merged image; old image bits are held unless explicitly loaded
  always_comb begin
    new_flags = old_flags;
    if (popf) begin
      new_flags          = c_EFLAGS_RST;
      new_flags[c_EF_CF] = pop_img[c_EF_CF];
      new_flags[c_EF_PF] = pop_img[c_EF_PF];
      new_flags[c_EF_AF] = pop_img[c_EF_AF];
      new_flags[c_EF_ZF] = pop_img[c_EF_ZF];
      new_flags[c_EF_SF] = pop_img[c_EF_SF];
      new_flags[c_EF_DF] = pop_img[c_EF_DF];
      new_flags[c_EF_OF] = pop_img[c_EF_OF];
    end else begin
      for (int i = 0; i < c_NFLAGS; i++) begin
        if (ld_flag[i]) begin
          new_flags[ef_pos(i)] = src[i];
        end
      end
      if (ld_df) begin
        new_flags[c_EF_DF] = df_val;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/flags_wb.sv
`default_nettype none
// ============================================================================
//  Module      : flags_wb
//  Description : Flags writeback stage. One-entry pending register between
//                EX and the architectural EFLAGS, with stall, flush and a
//                forwarded image that already includes the pending entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module flags_wb
  import flags_wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        wb_stall,
  input  logic        flush,
  input  logic [5:0]  alu1_flags,
  input  logic [5:0]  cmps_flags,
  input  logic        cmps_sel,
  input  logic [5:0]  ld_flag,
  input  logic        df_val_ex,
  input  logic        ld_df,
  input  logic        popf,
  input  logic [31:0] alu_res1,
  output logic [15:0] eflags,
  output logic [15:0] flags_fwd,
  output logic        flags_pending
);

  logic        r_wb_valid;
  logic        r_popf;
  logic [5:0]  r_ld_flag;
  logic [5:0]  r_src;
  logic        r_ld_df;
  logic        r_df_val;
  logic [15:0] r_pop_img;
  logic [15:0] r_eflags;

  logic        w_accept;
  logic        w_commit;
  logic [15:0] w_commit_flags;
  logic [15:0] w_fwd_flags;
  logic        w_unused_res;

  // Upper result half never carries flag information
  assign w_unused_res = &{1'b0, alu_res1[31:16]};

  // Handshake: the slot is free when empty or draining this cycle;
  // flush overrides both accept and commit
  assign ex_ready = ~r_wb_valid | ~wb_stall;
  assign w_accept = ex_valid & ex_ready & ~flush;
  assign w_commit = r_wb_valid & ~wb_stall & ~flush;

  // Pending register and architectural image update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_popf     <= 1'b0;
      r_ld_flag  <= 6'd0;
      r_src      <= 6'd0;
      r_ld_df    <= 1'b0;
      r_df_val   <= 1'b0;
      r_pop_img  <= 16'd0;
      r_eflags   <= c_EFLAGS_RST;
    end else begin
      if (w_commit) begin
        r_eflags <= w_commit_flags;
      end
      if (flush) begin
        r_wb_valid <= 1'b0;
      end else if (w_accept) begin
        r_wb_valid <= 1'b1;
        r_popf     <= popf;
        r_ld_flag  <= ld_flag;
        r_src      <= cmps_sel ? cmps_flags : alu1_flags;
        r_ld_df    <= ld_df;
        r_df_val   <= df_val_ex;
        r_pop_img  <= alu_res1[15:0];
      end else if (w_commit) begin
        r_wb_valid <= 1'b0;
      end
    end
  end

  // Merge used when the pending entry retires into eflags
  flags_merge u_merge_commit (
    .old_flags (r_eflags),
    .popf      (r_popf),
    .ld_flag   (r_ld_flag),
    .src       (r_src),
    .ld_df     (r_ld_df),
    .df_val    (r_df_val),
    .pop_img   (r_pop_img),
    .new_flags (w_commit_flags)
  );

  // Merge used for the forwarded image seen by younger instructions
  flags_merge u_merge_fwd (
    .old_flags (r_eflags),
    .popf      (r_popf),
    .ld_flag   (r_ld_flag),
    .src       (r_src),
    .ld_df     (r_ld_df),
    .df_val    (r_df_val),
    .pop_img   (r_pop_img),
    .new_flags (w_fwd_flags)
  );

  assign eflags        = r_eflags;
  assign flags_fwd     = r_wb_valid ? w_fwd_flags : r_eflags;
  assign flags_pending = r_wb_valid & (r_popf | r_ld_df | (|r_ld_flag));

endmodule
`default_nettype wire

// File: tb/tb_flags_wb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flags_wb
//  Description : Self-checking bench for flags_wb: directed scenarios plus a
//                randomized run against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flags_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic        wb_stall;
  logic        flush;
  logic [5:0]  alu1_flags;
  logic [5:0]  cmps_flags;
  logic        cmps_sel;
  logic [5:0]  ld_flag;
  logic        df_val_ex;
  logic        ld_df;
  logic        popf;
  logic [31:0] alu_res1;
  logic [15:0] eflags;
  logic [15:0] flags_fwd;
  logic        flags_pending;

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural image plus an optional pending entry
  logic [15:0] m_eflags;
  logic        m_valid;
  logic        m_popf;
  logic [5:0]  m_ld;
  logic [5:0]  m_src;
  logic        m_lddf;
  logic        m_df;
  logic [31:0] m_res;

  flags_wb dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .wb_stall      (wb_stall),
    .flush         (flush),
    .alu1_flags    (alu1_flags),
    .cmps_flags    (cmps_flags),
    .cmps_sel      (cmps_sel),
    .ld_flag       (ld_flag),
    .df_val_ex     (df_val_ex),
    .ld_df         (ld_df),
    .popf          (popf),
    .alu_res1      (alu_res1),
    .eflags        (eflags),
    .flags_fwd     (flags_fwd),
    .flags_pending (flags_pending)
  );

  always #5 clk = ~clk;

  // Apply one entry to an image, straight from the architectural rules
  function automatic logic [15:0] ref_apply(input logic [15:0] old, input logic pf,
                                            input logic [5:0] ld, input logic [5:0] src,
                                            input logic lddf, input logic df,
                                            input logic [31:0] res);
    int pos [6] = '{0, 2, 4, 6, 7, 11};
    logic [15:0] r;
    r = old;
    if (pf) begin
      r = 16'h0002;
      for (int i = 0; i < 6; i++) r[pos[i]] = res[pos[i]];
      r[10] = res[10];
    end else begin
      for (int i = 0; i < 6; i++) if (ld[i]) r[pos[i]] = src[i];
      if (lddf) r[10] = df;
    end
    return r;
  endfunction

  function automatic logic [15:0] ref_fwd();
    return m_valid ? ref_apply(m_eflags, m_popf, m_ld, m_src, m_lddf, m_df, m_res) : m_eflags;
  endfunction

  function automatic logic ref_pending();
    return m_valid & (m_popf | m_lddf | (m_ld != 6'd0));
  endfunction

  // Present one cycle of inputs, advance the model at the edge, settle
  task automatic drive_cycle(input logic ev, input logic stall, input logic fl,
                             input logic sel, input logic [5:0] alu, input logic [5:0] cmps,
                             input logic [5:0] ld, input logic lddf, input logic df,
                             input logic pf, input logic [31:0] res);
    logic rdy, acc, com;
    ex_valid = ev; wb_stall = stall; flush = fl; cmps_sel = sel;
    alu1_flags = alu; cmps_flags = cmps; ld_flag = ld; ld_df = lddf;
    df_val_ex = df; popf = pf; alu_res1 = res;
    @(posedge clk);
    rdy = ~m_valid | ~stall;
    acc = ev & rdy & ~fl;
    com = m_valid & ~stall & ~fl;
    if (com) m_eflags = ref_apply(m_eflags, m_popf, m_ld, m_src, m_lddf, m_df, m_res);
    if (fl) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1; m_popf = pf; m_ld = ld; m_src = sel ? cmps : alu;
      m_lddf = lddf; m_df = df; m_res = res;
    end else if (com) m_valid = 1'b0;
    #1;
  endtask

  task automatic idle_cycle();
    drive_cycle(0, 0, 0, 0, 6'd0, 6'd0, 6'd0, 0, 0, 0, 32'd0);
  endtask

  task automatic do_reset();
    ex_valid = 0; wb_stall = 0; flush = 0; cmps_sel = 0; alu1_flags = 0;
    cmps_flags = 0; ld_flag = 0; ld_df = 0; df_val_ex = 0; popf = 0; alu_res1 = 0;
    rst = 1'b1;
    m_eflags = 16'h0002; m_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    ex_valid = 0; wb_stall = 1; flush = 0; cmps_sel = 0; alu1_flags = 0;
    cmps_flags = 0; ld_flag = 0; ld_df = 0; df_val_ex = 0; popf = 0; alu_res1 = 0;
    rst = 1'b1;
    m_eflags = 16'h0002; m_valid = 1'b0;
    #12;
    checks++; if (eflags !== 16'h0002) begin failures++; $display("FAIL reset_eflags: got %h expected %h", eflags, 16'h0002); end
    checks++; if (flags_fwd !== 16'h0002) begin failures++; $display("FAIL reset_fwd: got %h expected %h", flags_fwd, 16'h0002); end
    checks++; if (flags_pending !== 1'b0) begin failures++; $display("FAIL reset_pending: got %b expected 0", flags_pending); end
    checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ex_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    wb_stall = 0;
  endtask

  task automatic test_single();
    drive_cycle(1, 0, 0, 0, 6'b001001, 6'd0, 6'h3F, 0, 0, 0, 32'd0);
    ex_valid = 0;
    #1;
    checks++; if (flags_fwd !== 16'h0043) begin failures++; $display("FAIL single_fwd: got %h expected %h", flags_fwd, 16'h0043); end
    checks++; if (eflags !== 16'h0002) begin failures++; $display("FAIL single_early: got %h expected %h", eflags, 16'h0002); end
    checks++; if (flags_pending !== 1'b1) begin failures++; $display("FAIL single_pending: got %b expected 1", flags_pending); end
    idle_cycle();
    checks++; if (eflags !== 16'h0043) begin failures++; $display("FAIL single_commit: got %h expected %h", eflags, 16'h0043); end
    checks++; if (flags_pending !== 1'b0) begin failures++; $display("FAIL single_drained: got %b expected 0", flags_pending); end
  endtask

  task automatic test_stall();
    drive_cycle(1, 0, 0, 0, 6'b000000, 6'd0, 6'b000001, 0, 0, 0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, 1, 0, 0, 6'h3F, 6'd0, 6'h3F, 0, 0, 0, 32'd0);
      checks++; if (ex_ready !== 1'b0) begin failures++; $display("FAIL stall_ready[%0d]: got %b expected 0", i, ex_ready); end
      checks++; if (eflags !== 16'h0043) begin failures++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, eflags, 16'h0043); end
    end
    idle_cycle();
    checks++; if (eflags !== 16'h0042) begin failures++; $display("FAIL stall_commit: got %h expected %h", eflags, 16'h0042); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_cycle(1, 0, 0, 0, 6'h3F, 6'd0, 6'b000001, 0, 0, 0, 32'd0);
    checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready0: got %b expected 1", ex_ready); end
    drive_cycle(1, 0, 0, 0, 6'h3F, 6'd0, 6'b001000, 0, 0, 0, 32'd0);
    checks++; if (eflags !== 16'h0003) begin failures++; $display("FAIL b2b_first: got %h expected %h", eflags, 16'h0003); end
    checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready1: got %b expected 1", ex_ready); end
    idle_cycle();
    checks++; if (eflags !== 16'h0043) begin failures++; $display("FAIL b2b_second: got %h expected %h", eflags, 16'h0043); end
  endtask

  task automatic test_popf();
    drive_cycle(1, 0, 0, 1, 6'h3F, 6'h3F, 6'd0, 0, 0, 1, 32'h0000_0CD5);
    idle_cycle();
    checks++; if (eflags !== 16'h0CD7) begin failures++; $display("FAIL popf: got %h expected %h", eflags, 16'h0CD7); end
  endtask

  task automatic test_flush();
    drive_cycle(1, 0, 0, 0, 6'd0, 6'd0, 6'h3F, 0, 0, 0, 32'd0);
    drive_cycle(1, 0, 1, 0, 6'h3F, 6'd0, 6'h3F, 0, 0, 0, 32'd0);
    checks++; if (flags_pending !== 1'b0) begin failures++; $display("FAIL flush_pending: got %b expected 0", flags_pending); end
    checks++; if (eflags !== 16'h0CD7) begin failures++; $display("FAIL flush_eflags: got %h expected %h", eflags, 16'h0CD7); end
    checks++; if (flags_fwd !== 16'h0CD7) begin failures++; $display("FAIL flush_fwd: got %h expected %h", flags_fwd, 16'h0CD7); end
    idle_cycle();
    checks++; if (eflags !== 16'h0CD7) begin failures++; $display("FAIL flush_nocapture: got %h expected %h", eflags, 16'h0CD7); end
  endtask

  task automatic test_cmps_df_rst();
    do_reset();
    drive_cycle(1, 0, 0, 1, 6'h3F, 6'b100000, 6'h3F, 1, 1, 0, 32'd0);
    idle_cycle();
    checks++; if (eflags !== 16'h0C02) begin failures++; $display("FAIL cmps_df: got %h expected %h", eflags, 16'h0C02); end
    drive_cycle(1, 1, 0, 0, 6'h3F, 6'd0, 6'h3F, 0, 0, 0, 32'd0);
    rst = 1'b1;
    m_eflags = 16'h0002; m_valid = 1'b0;
    #1;
    checks++; if (eflags !== 16'h0002) begin failures++; $display("FAIL midrst_eflags: got %h expected %h", eflags, 16'h0002); end
    checks++; if (flags_pending !== 1'b0) begin failures++; $display("FAIL midrst_pending: got %b expected 0", flags_pending); end
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycle();
    checks++; if (eflags !== 16'h0002) begin failures++; $display("FAIL midrst_nocommit: got %h expected %h", eflags, 16'h0002); end
  endtask

  task automatic test_random();
    logic [15:0] exp_fwd;
    for (int n = 0; n < 400; n++) begin
      drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1,
                  6'($urandom), 6'($urandom),
                  ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7) == 0, $urandom);
      exp_fwd = ref_fwd();
      checks++; if (eflags !== m_eflags) begin failures++; $display("FAIL rnd_eflags[%0d]: got %h expected %h", n, eflags, m_eflags); end
      checks++; if (flags_fwd !== exp_fwd) begin failures++; $display("FAIL rnd_fwd[%0d]: got %h expected %h", n, flags_fwd, exp_fwd); end
      checks++; if (flags_pending !== ref_pending()) begin failures++; $display("FAIL rnd_pending[%0d]: got %b expected %b", n, flags_pending, ref_pending()); end
      checks++; if (ex_ready !== (~m_valid | ~wb_stall)) begin failures++; $display("FAIL rnd_ready[%0d]: got %b expected %b", n, ex_ready, ~m_valid | ~wb_stall); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_popf();
    test_flush();
    test_cmps_df_rst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flags_wb.md
FLAGS_WB -- requirements
Module: flags_wb

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on its rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 ex_valid  in  1  the EX stage presents a flag update this cycle.
REQ-004 ex_ready  out  1  flags_wb accepts the EX update this cycle.
REQ-005 wb_stall  in  1  writeback stall; blocks commit of the pending entry.
REQ-006 flush  in  1  discards the pending and incoming entries (branch mispredict / fault).
REQ-007 alu1_flags  in  6  ALU1 flags; bit order CF,PF,AF,ZF,SF,OF = bits 0..5.
REQ-008 cmps_flags  in  6  CMPS flags; same bit order as alu1_flags.
REQ-009 cmps_sel  in  1  1 selects cmps_flags, 0 selects alu1_flags.
REQ-010 ld_flag  in  6  per-flag load enables (CF..OF), already gated by ALU1 for zero-count shifts.
REQ-011 df_val_ex  in  1  new DF value.
REQ-012 ld_df  in  1  DF load enable.
REQ-013 popf  in  1  full flag load from alu_res1.
REQ-014 alu_res1  in  32  ALU1 result; only bits [15:0] are used.
REQ-015 eflags  out  16  architectural flags image.
REQ-016 flags_fwd  out  16  forwarded image, including any pending entry.
REQ-017 flags_pending  out  1  the pending entry writes at least one flag or DF.

Function
REQ-018 Input handshake:
- ex_ready SHALL be high when wb_valid is low, or when wb_valid is high and wb_stall is low.
- An entry is accepted when ex_valid and ex_ready are both high and flush is low.
REQ-019 An accepted entry SHALL be latched into a one-entry pending register (wb_valid=1) at the same rising edge.
REQ-020 Commit:
- The pending entry commits on an edge where wb_valid=1, wb_stall=0 and flush=0.
- Commit and a new accept on the same edge SHALL both occur (back-to-back throughput of one per cycle).
REQ-021 After a commit with no new accept, wb_valid SHALL clear.
REQ-022 Merge rule, for each flag i: new[i] = ld_flag[i] ? src[i] : old[i], where src = cmps_sel ? cmps_flags : alu1_flags.
REQ-023 DF SHALL be set to df_val_ex when ld_df=1, and hold otherwise.
REQ-024 POPF:
- When popf=1, the entry loads CF,PF,AF,ZF,SF,DF,OF from alu_res1 bits 0,2,4,6,7,10,11.
- ld_flag, ld_df and cmps_sel are ignored.
REQ-025 eflags layout: CF bit0, bit1 constant 1, PF bit2, AF bit4, ZF bit6, SF bit7, DF bit10, OF bit11; all other bits 0.
REQ-026 flags_fwd SHALL be combinational and equal to the merge of the pending entry onto eflags when wb_valid=1, else eflags.
REQ-027 flags_pending SHALL equal wb_valid & (popf_q | ld_df_q | |ld_flag_q).
REQ-028 Flush:
- flush=1 clears wb_valid at the next edge.
- The pending entry is not committed and no incoming entry is captured.
- Flush takes priority over commit and accept; ex_ready stays per REQ-018.
REQ-029 An entry whose enables are all zero SHALL still occupy the pipeline and commit with no change to eflags.
REQ-030 eflags SHALL change only on commit.

Reset
REQ-031 On rst, eflags SHALL be 16'h0002 and wb_valid SHALL be 0; flags_fwd equals 16'h0002, flags_pending=0 and ex_ready=1 while rst is held.
REQ-032 Asserting rst mid-operation SHALL drop any pending entry without committing it.

Structure
REQ-033 Shared package contents:
- flag index constants CF=0, PF=1, AF=2, ZF=3, SF=4, OF=5;
- EFLAGS bit positions (CF 0, PF 2, AF 4, ZF 6, SF 7, DF 10, OF 11);
- EFLAGS reset constant 16'h0002.
REQ-034 The merge logic SHALL be one combinational sub-module, flags_merge, instantiated once for the commit path and once for flags_fwd.

Verification
REQ-035 Reset, then one entry (alu1_flags=6'b001001, ld_flag=6'h3F, cmps_sel=0) -> flags_fwd=16'h0043 one edge after accept, eflags=16'h0043 one edge later.
REQ-036 wb_stall=1 for 3 cycles with an entry pending -> ex_ready=0, eflags unchanged; wb_stall falls -> commit on the next edge.
REQ-037 Back-to-back entries with ld_flag=6'b000001 (CF=1), then ld_flag=6'b001000 (ZF=1) -> eflags 16'h0003, then 16'h0043; ex_ready stays 1.
REQ-038 popf=1, alu_res1=32'h0000_0CD5, ld_flag=0 -> eflags=16'h0CD7.
REQ-039 Pending entry plus flush=1 while wb_stall=0 -> no commit, wb_valid=0, eflags unchanged; the simultaneously offered entry is not captured.
REQ-040 cmps_sel=1, cmps_flags=6'b100000, ld_flag=6'h3F, ld_df=1, df_val_ex=1 starting from 16'h0002 -> eflags=16'h0C02; then rst asserted with an entry pending -> eflags=16'h0002, wb_valid=0.
